// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the 32x16 data memory: fixed priority
// with a burst limit, one access per clock, registered read return per requester.

module dmem_rd_ret #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst,
  input  logic          i_take,
  input  logic [DW-1:0] i_rdata,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata
);
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

  // rdata holds until the next read for this requester
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_take;
      if (i_take) r_rdata <= i_rdata;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
endmodule

module dmem_arbiter #(
  parameter int AW        = 5,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk_i,
  input  logic          rst,
  input  logic          r0_req_i,
  input  logic          r0_we_i,
  input  logic [AW-1:0] r0_adr_i,
  input  logic [DW-1:0] r0_data_i,
  output logic          r0_gnt_o,
  output logic [DW-1:0] r0_rdata_o,
  output logic          r0_rvalid_o,
  input  logic          r1_req_i,
  input  logic          r1_we_i,
  input  logic [AW-1:0] r1_adr_i,
  input  logic [DW-1:0] r1_data_i,
  output logic          r1_gnt_o,
  output logic [DW-1:0] r1_rdata_o,
  output logic          r1_rvalid_o,
  output logic          mem_ena_wr_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [1:0]    owner_o
);
  localparam int NREQ = 2;
  localparam int CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_under;

  logic [NREQ-1:0]         w_req, w_we, w_gnt_raw, w_gnt, w_rvalid;
  logic [NREQ-1:0][AW-1:0] w_adr;
  logic [NREQ-1:0][DW-1:0] w_data, w_rdata;

  assign w_req  = {r1_req_i, r0_req_i};
  assign w_we   = {r1_we_i, r0_we_i};
  assign w_adr  = {r1_adr_i, r0_adr_i};
  assign w_data = {r1_data_i, r0_data_i};
  assign w_under = (r_cnt < MAXC);

  // The current owner keeps the port while under its burst limit or uncontested
  always_comb begin
    w_gnt_raw = '0;
    case (r_state)
      OWN0: begin
        if (w_req[0] && (w_under || !w_req[1])) w_gnt_raw[0] = 1'b1;
        else if (w_req[1])                      w_gnt_raw[1] = 1'b1;
      end
      OWN1: begin
        if (w_req[1] && (w_under || !w_req[0])) w_gnt_raw[1] = 1'b1;
        else if (w_req[0])                      w_gnt_raw[0] = 1'b1;
      end
      default: begin
        if (w_req[0])      w_gnt_raw[0] = 1'b1;
        else if (w_req[1]) w_gnt_raw[1] = 1'b1;
      end
    endcase
  end

  // Reset aborts the in-flight transfer combinationally, so no write escapes
  assign w_gnt = w_gnt_raw & {NREQ{rst}};

  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_nxt   = '0;
    if (w_gnt[0]) begin
      w_state_nxt = OWN0;
      w_cnt_nxt   = (r_state != OWN0) ? CW'(1) : (r_cnt == MAXC) ? MAXC : r_cnt + CW'(1);
    end else if (w_gnt[1]) begin
      w_state_nxt = OWN1;
      w_cnt_nxt   = (r_state != OWN1) ? CW'(1) : (r_cnt == MAXC) ? MAXC : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    mem_ena_wr_o = 1'b0;
    mem_adr_o    = '0;
    mem_data_o   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        mem_ena_wr_o = w_we[k];
        mem_adr_o    = w_adr[k];
        mem_data_o   = w_data[k];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_ret
      dmem_rd_ret #(.DW(DW)) u_ret (
        .clk_i    (clk_i),
        .rst      (rst),
        .i_take   (w_gnt[g] & ~w_we[g]),
        .i_rdata  (mem_rdata_i),
        .o_rvalid (w_rvalid[g]),
        .o_rdata  (w_rdata[g])
      );
    end
  endgenerate

  assign r0_gnt_o    = w_gnt[0];
  assign r1_gnt_o    = w_gnt[1];
  assign r0_rvalid_o = w_rvalid[0];
  assign r1_rvalid_o = w_rvalid[1];
  assign r0_rdata_o  = w_rdata[0];
  assign r1_rdata_o  = w_rdata[1];
  assign owner_o     = r_state;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against an
// ownership/run-length reference model and a golden memory image.

module tb_dmem_arbiter;
  localparam int AW = 5, DW = 16, MB = 4;

  logic          clk_i = 1'b0, rst = 1'b0;
  logic          r0_req_i = 0, r0_we_i = 0, r1_req_i = 0, r1_we_i = 0;
  logic [AW-1:0] r0_adr_i = '0, r1_adr_i = '0;
  logic [DW-1:0] r0_data_i = '0, r1_data_i = '0;
  logic          r0_gnt_o, r0_rvalid_o, r1_gnt_o, r1_rvalid_o, mem_ena_wr_o;
  logic [DW-1:0] r0_rdata_o, r1_rdata_o, mem_data_o, mem_rdata_i;
  logic [AW-1:0] mem_adr_o;
  logic [1:0]    owner_o;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk_i), .rst(rst),
    .r0_req_i(r0_req_i), .r0_we_i(r0_we_i), .r0_adr_i(r0_adr_i), .r0_data_i(r0_data_i),
    .r0_gnt_o(r0_gnt_o), .r0_rdata_o(r0_rdata_o), .r0_rvalid_o(r0_rvalid_o),
    .r1_req_i(r1_req_i), .r1_we_i(r1_we_i), .r1_adr_i(r1_adr_i), .r1_data_i(r1_data_i),
    .r1_gnt_o(r1_gnt_o), .r1_rdata_o(r1_rdata_o), .r1_rvalid_o(r1_rvalid_o),
    .mem_ena_wr_o(mem_ena_wr_o), .mem_adr_o(mem_adr_o), .mem_data_o(mem_data_o),
    .mem_rdata_i(mem_rdata_i), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  // The memory the arbiter drives
  logic [DW-1:0] tb_mem [32];
  always @(posedge clk_i) if (mem_ena_wr_o) tb_mem[mem_adr_o] <= mem_data_o;
  assign mem_rdata_i = tb_mem[mem_adr_o];

  // Reference model state
  logic [DW-1:0] ref_mem [32];
  int            last_owner, run;
  logic          pend_v [2];
  logic [DW-1:0] pend_d [2];
  int            n_chk = 0, n_err = 0;
  logic          obs_g0, obs_g1, obs_ena, obs_rv0, obs_rv1;
  logic [1:0]    obs_own;
  logic [AW-1:0] obs_adr;
  logic [DW-1:0] obs_rd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit a, input bit b);
    if (a && b) begin
      if (last_owner == 0) return 1;
      if (run < MB) return last_owner;
      return 3 - last_owner;
    end
    if (a) return 1;
    if (b) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    last_owner = 0; run = 0;
    pend_v[0] = 0; pend_v[1] = 0;
  endtask

  // Check one cycle at the falling edge, advance the model, return at posedge+1
  task automatic step();
    int g;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk_i);
    g = pick(r0_req_i, r1_req_i);
    obs_g0 = r0_gnt_o; obs_g1 = r1_gnt_o; obs_own = owner_o; obs_ena = mem_ena_wr_o;
    obs_adr = mem_adr_o; obs_rv0 = r0_rvalid_o; obs_rv1 = r1_rvalid_o; obs_rd0 = r0_rdata_o;
    chk("owner", 32'(owner_o), 32'(last_owner));
    chk("gnt0", 32'(r0_gnt_o), 32'(g == 1));
    chk("gnt1", 32'(r1_gnt_o), 32'(g == 2));
    chk("rvalid0", 32'(r0_rvalid_o), 32'(pend_v[0]));
    chk("rvalid1", 32'(r1_rvalid_o), 32'(pend_v[1]));
    if (pend_v[0]) chk("rdata0", 32'(r0_rdata_o), 32'(pend_d[0]));
    if (pend_v[1]) chk("rdata1", 32'(r1_rdata_o), 32'(pend_d[1]));
    we = (g == 1) ? r0_we_i : (g == 2) ? r1_we_i : 1'b0;
    a  = (g == 1) ? r0_adr_i : (g == 2) ? r1_adr_i : '0;
    d  = (g == 1) ? r0_data_i : (g == 2) ? r1_data_i : '0;
    chk("mem_we", 32'(mem_ena_wr_o), 32'(we));
    chk("mem_adr", 32'(mem_adr_o), 32'(a));
    chk("mem_data", 32'(mem_data_o), 32'(d));
    pend_v[0] = (g == 1) && !we;
    pend_v[1] = (g == 2) && !we;
    if (g != 0 && !we) pend_d[g-1] = ref_mem[a];
    if (g != 0 && we) ref_mem[a] = d;
    if (g == 0) begin last_owner = 0; run = 0; end
    else if (g == last_owner) run = (run < MB) ? run + 1 : MB;
    else begin last_owner = g; run = 1; end
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [3:0] pat0, pat1;
    logic [1:0] own_seq [9];
    logic [DW-1:0] old;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i] = 16'(i * 16'h0101); ref_mem[i] = 16'(i * 16'h0101);
    end
    model_reset();

    // Reset held with both requesting
    r0_req_i = 1; r1_req_i = 1; r0_adr_i = 5'd1; r1_adr_i = 5'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst_gnt", {30'd0, r1_gnt_o, r0_gnt_o}, 32'd0);
      chk("rst_we_own", {29'd0, mem_ena_wr_o, owner_o}, 32'd0);
      chk("rst_rv", {30'd0, r1_rvalid_o, r0_rvalid_o}, 32'd0);
    end
    @(posedge clk_i); #1; rst = 1;
    step();
    chk("first_gnt_r0", 32'(obs_g0), 32'd1);
    r0_req_i = 0; r1_req_i = 0;
    step();

    // r0 write then read of the same word
    r0_req_i = 1; r0_we_i = 1; r0_adr_i = 5'd5; r0_data_i = 16'hA5A5;
    step(); chk("wr5_gnt", 32'(obs_g0), 32'd1);
    r0_we_i = 0;
    step(); chk("rd5_gnt", 32'(obs_g0), 32'd1);
    r0_req_i = 0;
    step();
    chk("rd5_rv", 32'(obs_rv0), 32'd1);
    chk("rd5_data", 32'(obs_rd0), 32'hA5A5);
    chk("rd5_rv1", 32'(obs_rv1), 32'd0);
    step();

    // Both requesting reads: runs of MAX_BURST
    own_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    r0_req_i = 1; r1_req_i = 1; r0_we_i = 0; r1_we_i = 0; r1_adr_i = 5'd9;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 9) chk("burst_gnt", {30'd0, obs_g1, obs_g0}, (i >= 4 && i < 8) ? 32'd2 : 32'd1);
      if (i > 0) chk("burst_own", 32'(obs_own), 32'(own_seq[i-1]));
    end
    r0_req_i = 0; r1_req_i = 0;
    step();

    // r0 alone: no burst limit, then r1 takes over from a saturated run
    r0_req_i = 1; pat0 = 0;
    for (int i = 0; i < 10; i++) begin
      step(); chk("solo_gnt0", 32'(obs_g0), 32'd1);
    end
    r1_req_i = 1;
    step(); chk("sat_gnt1", {30'd0, obs_g1, obs_g0}, 32'd2);

    // r1 write of word 31 while r0 withdraws
    r0_req_i = 0; r1_we_i = 1; r1_adr_i = 5'd31; r1_data_i = 16'h0001;
    step();
    chk("w31_we", 32'(obs_ena), 32'd1);
    chk("w31_adr", 32'(obs_adr), 32'd31);
    r1_req_i = 0; r1_we_i = 0;
    step();
    chk("w31_mem", 32'(tb_mem[31]), 32'h0001);

    // Reset during an r0 write grant with an r1 rvalid pending
    r1_req_i = 1; r1_adr_i = 5'd3;
    step();
    old = tb_mem[9];
    r1_req_i = 0; r0_req_i = 1; r0_we_i = 1; r0_adr_i = 5'd9; r0_data_i = ~old;
    #1; chk("pre_rst_we", 32'(mem_ena_wr_o), 32'd1);
    chk("pre_rst_rv1", 32'(r1_rvalid_o), 32'd1);
    rst = 0; #1;
    chk("mid_rst_we", 32'(mem_ena_wr_o), 32'd0);
    chk("mid_rst_gnt0", 32'(r0_gnt_o), 32'd0);
    chk("mid_rst_rv1", 32'(r1_rvalid_o), 32'd0);
    @(posedge clk_i); #1;
    rst = 1; r0_req_i = 0; r0_we_i = 0;
    model_reset();
    chk("mid_rst_mem", 32'(tb_mem[9]), 32'(old));
    step();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      pat0 = 4'($urandom_range(15)); pat1 = 4'($urandom_range(15));
      if (obs_g0 || !r0_req_i) begin
        r0_req_i = pat0[0] | pat0[1];
        r0_we_i = 1'($urandom_range(1)); r0_adr_i = 5'($urandom_range(7));
        r0_data_i = 16'($urandom);
      end else if (pat0 == 4'd0) r0_req_i = 0;
      if (obs_g1 || !r1_req_i) begin
        r1_req_i = pat1[0] | pat1[1];
        r1_we_i = 1'($urandom_range(1)); r1_adr_i = 5'($urandom_range(7));
        r1_data_i = 16'($urandom);
      end else if (pat1 == 4'd0) r1_req_i = 0;
      step();
    end
    r0_req_i = 0; r1_req_i = 0;
    step(); step();
    for (int i = 0; i < 32; i++) chk("final_mem", 32'(tb_mem[i]), 32'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
